btn_debounce_sched: RTL and testbench
=====================================

Name: btn_debounce_sched

Overview:
Debounces NBTN push-buttons using one shared countdown timer instead of one timer per button. A round-robin scheduler grants the timer to one button whose synchronized level differs from its debounced level. It commits the new level only if the input stays stable for the whole window. Each committed change also goes out as an event on a valid/ready stream, which feeds the button-command logic between the raw pads and the user-interface FSMs.

Parameters:
NBTN, 4, number of buttons (2..16)
TIME_PERIOD, 75000, stable-window length in clocks (2..2**TW)
TW, 17, timer width in bits
IW, 2, index width, must satisfy 2**IW >= NBTN

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_btn  in  NBTN  raw, asynchronous button inputs
o_debounced  out  NBTN  debounced button levels
o_busy  out  1  high while the timer is granted (state TIMING or COMMIT)
o_grant_idx  out  IW  index currently owning the timer (valid when o_busy)
o_evt_valid  out  1  event available
i_evt_ready  in  1  consumer accepts the event
o_evt_idx  out  IW  button index of the event
o_evt_level  out  1  new debounced level of that button
o_abort_cnt  out  16  bounce-abort counter (see Optional Feature)

Behaviour:
- Reset (async, while i_reset=1):
  - All outputs 0.
  - Sync flops 0, timer 0, state IDLE, round-robin pointer rr=0.
  - Any in-progress window or pending event is discarded.
- Synchronizer: each i_btn bit passes through a 2-FF chain to sync[i].
- pending[i] = sync[i] ^ o_debounced[i], evaluated combinationally.
- FSM states: IDLE, TIMING, COMMIT.
- IDLE:
  - If pending != 0, grant the first set bit searching upward from rr, wrapping modulo NBTN.
  - Latch it into idx, load timer = TIME_PERIOD-1, go to TIMING.
  - If pending == 0, stay in IDLE.
- TIMING:
  - Every cycle, if sync[idx] == o_debounced[idx] (bounce-back): abort, rr <= (idx+1) mod NBTN, go to IDLE. The abort check has priority over timer expiry.
  - Else if timer == 0: go to COMMIT.
  - Else timer <= timer-1.
- COMMIT:
  - If (!o_evt_valid || i_evt_ready): toggle o_debounced[idx], load o_evt_idx=idx and o_evt_level=new level, set o_evt_valid=1, rr <= (idx+1) mod NBTN, go to IDLE.
  - Otherwise stall in COMMIT. The decision is final, so sync changes during the stall are ignored. No event is ever dropped.
- Event stream:
  - o_evt_valid stays high and the payload stays stable until accepted (valid && ready at a clock edge).
  - Clear o_evt_valid on acceptance unless a COMMIT reloads it in the same cycle (back-to-back events allowed).
- Latency: with no contention and the event slot free, o_debounced and o_evt_valid change TIME_PERIOD+4 clock edges after an i_btn edge that is then held stable.
- Contention: buttons not granted wait. Waiting time does not count toward their window. A non-granted button whose pending drops back to 0 simply vanishes.
- Fairness: after serving (commit or abort) button k, the next search starts at k+1, so no button is starved while others chatter.
- Widths: the timer never underflows; TIME_PERIOD-1 must fit in TW bits.

Optional Feature:
- Macro: DEBOUNCE_ABORT_CNT_EN.
- Defined:
  - o_abort_cnt increments by 1 on every TIMING abort.
  - It saturates at 16'hFFFF and resets to 0.
- Undefined: o_abort_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Reset then hold: NBTN=4, TIME_PERIOD=8, i_btn=4'b0000 -> o_debounced=0, o_evt_valid=0, o_busy=0 indefinitely.
- Clean press: i_btn[2] 0->1, held, i_evt_ready=1 -> o_debounced[2]=1 and event {idx=2, level=1} exactly 12 edges later; o_busy high for 9 cycles.
- Bounce: i_btn[1] toggles 1,0,1,0 with period 3 clocks, then holds 1 -> aborts seen (o_abort_cnt=3 with macro, 0 without), single event {1,1} only after 8 stable cycles.
- Contention: i_btn[0] and i_btn[3] rise on the same cycle -> button 0 commits first, button 3 commits 10 edges later (rr order); two events in order 0, 3.
- Backpressure: i_evt_ready=0, press buttons 0 then 1 -> first event held stable; FSM stalls in COMMIT for button 1 with o_debounced[1]=0; raising ready yields event {1,1} the cycle after {0,1} is accepted.
- Async reset mid-window: assert i_reset during TIMING -> all outputs 0 immediately without a clock edge; after release, a still-pressed button restarts the full 12-edge sequence.

Source files
------------

// File: rtl/btn_debounce_sched_if.sv
// Event stream carrying committed button-level changes from btn_debounce_sched
// to the button-command logic.
interface btn_debounce_sched_if #(
    parameter int IW = 2
);
    logic          evt_valid;
    logic          evt_ready;
    logic [IW-1:0] evt_idx;
    logic          evt_level;

    modport master (output evt_valid, output evt_idx, output evt_level, input evt_ready);
    modport slave  (input evt_valid, input evt_idx, input evt_level, output evt_ready);
endinterface

// File: rtl/btn_debounce_sched.sv
// Multi-button debouncer sharing one countdown timer among all buttons via a
// round-robin grant. Optional bounce-abort counter: define DEBOUNCE_ABORT_CNT_EN.
module btn_debounce_sched #(
    parameter int NBTN        = 4,
    parameter int TIME_PERIOD = 75000,
    parameter int TW          = 17,
    parameter int IW          = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NBTN-1:0]       i_btn,
    output logic [NBTN-1:0]       o_debounced,
    output logic                  o_busy,
    output logic [IW-1:0]         o_grant_idx,
    btn_debounce_sched_if.master  evt,
    output logic [15:0]           o_abort_cnt
);
    typedef enum logic [1:0] {IDLE, TIMING, COMMIT} state_t;

    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIME_PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NBTN - 1);

    state_t          state, state_nx;
    logic [NBTN-1:0] sync_q1, sync_q2, pending;
    logic [IW-1:0]   idx, rr, pick, idx_next;
    logic [TW-1:0]   timer;
    logic            found, do_grant, do_abort, do_commit;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= i_btn;
            sync_q2 <= sync_q1;
        end
    end

    assign pending  = sync_q2 ^ o_debounced;
    assign idx_next = (idx == LAST_IDX) ? '0 : idx + IW'(1);

    // First pending button at or above rr, wrapping at NBTN.
    always_comb begin
        int unsigned j;
        j     = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned k = 0; k < NBTN; k++) begin
            j = 32'(rr) + k;
            if (j >= 32'(NBTN)) j = j - 32'(NBTN);
            if (!found && pending[j[IW-1:0]]) begin
                found = 1'b1;
                pick  = j[IW-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        do_grant  = 1'b0;
        do_abort  = 1'b0;
        do_commit = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    do_grant = 1'b1;
                    state_nx = TIMING;
                end
            end
            TIMING: begin
                if (sync_q2[idx] == o_debounced[idx]) begin
                    do_abort = 1'b1;
                    state_nx = IDLE;
                end else if (timer == '0) begin
                    state_nx = COMMIT;
                end
            end
            COMMIT: begin
                if (!evt.evt_valid || evt.evt_ready) begin
                    do_commit = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            idx           <= '0;
            rr            <= '0;
            timer         <= '0;
            o_debounced   <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_idx   <= '0;
            evt.evt_level <= 1'b0;
        end else begin
            if (do_grant) begin
                idx   <= pick;
                timer <= TIMER_LOAD;
            end else if (state == TIMING && !do_abort && timer != '0) begin
                timer <= timer - TW'(1);
            end

            if (do_abort || do_commit) rr <= idx_next;

            // A commit may refill the slot in the same cycle the old event is taken.
            if (do_commit) begin
                o_debounced[idx] <= ~o_debounced[idx];
                evt.evt_valid    <= 1'b1;
                evt.evt_idx      <= idx;
                evt.evt_level    <= ~o_debounced[idx];
            end else if (evt.evt_valid && evt.evt_ready) begin
                evt.evt_valid <= 1'b0;
            end
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_grant_idx = idx;

`ifdef DEBOUNCE_ABORT_CNT_EN
    logic [15:0] abort_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)                          abort_cnt <= '0;
        else if (do_abort && abort_cnt != '1) abort_cnt <= abort_cnt + 16'd1;
    end

    assign o_abort_cnt = abort_cnt;
`else
    assign o_abort_cnt = '0;
`endif

endmodule

// File: tb/tb_btn_debounce_sched.sv
// Bench for btn_debounce_sched: directed scenarios with fixed expectations plus
// randomized button activity checked every cycle against a window-age model.
module tb_btn_debounce_sched;
    localparam int NBTN = 4;
    localparam int TP   = 8;
    localparam int TW   = 4;
    localparam int IW   = 2;
`ifdef DEBOUNCE_ABORT_CNT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic [NBTN-1:0] i_btn = '0;
    logic [NBTN-1:0] deb;
    logic            busy;
    logic [IW-1:0]   gidx;
    logic [15:0]     abort_cnt;

    btn_debounce_sched_if #(.IW(IW)) evt_if ();

    btn_debounce_sched #(.NBTN(NBTN), .TIME_PERIOD(TP), .TW(TW), .IW(IW)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_btn       (i_btn),
        .o_debounced (deb),
        .o_busy      (busy),
        .o_grant_idx (gidx),
        .evt         (evt_if.master),
        .o_abort_cnt (abort_cnt)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a granted button's window is measured by its age since grant; it
    // needs TP stable checks, then commits once the event slot is free.
    logic [NBTN-1:0] m_s1, m_s2, m_deb;
    int              m_owner, m_age, m_rr, m_aborts, m_ev_idx;
    logic            m_ev_valid, m_ev_lvl;

    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            m_owner = -1; m_age = 0; m_rr = 0; m_aborts = 0;
            m_ev_valid = 1'b0; m_ev_idx = 0; m_ev_lvl = 1'b0;
        end else begin
            logic [NBTN-1:0] pend;
            bit accept, commit;
            pend   = m_s2 ^ m_deb;
            accept = m_ev_valid && evt_if.evt_ready;
            commit = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < NBTN; k++)
                    if (m_owner < 0 && pend[(m_rr + k) % NBTN]) begin
                        m_owner = (m_rr + k) % NBTN;
                        m_age   = 0;
                    end
            end else if (m_age < TP) begin
                if (m_s2[m_owner] == m_deb[m_owner]) begin
                    m_rr    = (m_owner + 1) % NBTN;
                    m_owner = -1;
                    if (m_aborts < 65535) m_aborts++;
                end else begin
                    m_age++;
                end
            end else if (!m_ev_valid || evt_if.evt_ready) begin
                m_deb[m_owner] = ~m_deb[m_owner];
                m_ev_idx = m_owner;
                m_ev_lvl = m_deb[m_owner];
                commit   = 1;
                m_rr     = (m_owner + 1) % NBTN;
                m_owner  = -1;
            end
            if (commit)      m_ev_valid = 1'b1;
            else if (accept) m_ev_valid = 1'b0;
            m_s2 = m_s1;
            m_s1 = i_btn;
        end
    end

    always @(negedge i_clk) begin
        if (!i_reset) begin
            chk("debounced", deb, m_deb);
            chk("busy", busy, m_owner >= 0);
            if (m_owner >= 0) chk("grant_idx", gidx, m_owner);
            chk("evt_valid", evt_if.evt_valid, m_ev_valid);
            if (m_ev_valid) begin
                chk("evt_idx", evt_if.evt_idx, m_ev_idx);
                chk("evt_level", evt_if.evt_level, m_ev_lvl);
            end
            chk("abort_cnt", abort_cnt, ABORT_EN ? m_aborts : 0);
        end
    end

    task automatic do_reset();
        i_btn   = '0;
        i_reset = 1'b1;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    task automatic wait_evt(input int c0, input int budget);
        while (!evt_if.evt_valid && cyc - c0 < budget) @(negedge i_clk);
    endtask

    int c0, nb, nev;
    int ev_i[4];
    int ev_c[4];

    initial begin
        evt_if.evt_ready = 1'b1;
        do_reset();

        repeat (20) begin
            @(negedge i_clk);
            chk("idle_deb", deb, 0);
            chk("idle_valid", evt_if.evt_valid, 0);
            chk("idle_busy", busy, 0);
        end

        // Clean press on button 2.
        i_btn[2] = 1'b1;
        c0 = cyc; nb = 0;
        while (!evt_if.evt_valid && cyc - c0 < 40) begin
            @(negedge i_clk);
            if (busy) nb++;
        end
        chk("press_latency", cyc - c0, 12);
        chk("press_busy_cycles", nb, 9);
        chk("press_evt_idx", evt_if.evt_idx, 2);
        chk("press_evt_level", evt_if.evt_level, 1);
        chk("press_deb", deb, 4'b0100);
        repeat (15) @(negedge i_clk);

        // Bounce on button 1: three short high phases, then a steady high.
        do_reset();
        nev = 0;
        for (int ph = 0; ph < 6; ph++) begin
            i_btn[1] = (ph % 2 == 0);
            repeat (3) begin
                @(negedge i_clk);
                if (evt_if.evt_valid) nev++;
            end
        end
        i_btn[1] = 1'b1;
        repeat (25) begin
            @(negedge i_clk);
            if (evt_if.evt_valid) begin
                nev++;
                chk("bounce_evt_idx", evt_if.evt_idx, 1);
                chk("bounce_evt_level", evt_if.evt_level, 1);
            end
        end
        chk("bounce_evt_count", nev, 1);
        chk("bounce_aborts", abort_cnt, ABORT_EN ? 3 : 0);

        // Contention: buttons 0 and 3 rise together.
        do_reset();
        i_btn = 4'b1001;
        c0 = cyc; nev = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (evt_if.evt_valid && nev < 4) begin
                ev_i[nev] = evt_if.evt_idx;
                ev_c[nev] = cyc - c0;
                nev++;
            end
        end
        chk("contend_count", nev, 2);
        chk("contend_first_idx", ev_i[0], 0);
        chk("contend_first_lat", ev_c[0], 12);
        chk("contend_second_idx", ev_i[1], 3);
        chk("contend_spacing", ev_c[1] - ev_c[0], 10);

        // Backpressure: hold the slot, second commit stalls.
        do_reset();
        evt_if.evt_ready = 1'b0;
        i_btn[0] = 1'b1;
        repeat (2) @(negedge i_clk);
        i_btn[1] = 1'b1;
        repeat (30) begin
            @(negedge i_clk);
            if (evt_if.evt_valid) chk("bp_hold_idx", evt_if.evt_idx, 0);
        end
        chk("bp_valid", evt_if.evt_valid, 1);
        chk("bp_level", evt_if.evt_level, 1);
        chk("bp_stall_deb", deb, 4'b0001);
        chk("bp_stall_busy", busy, 1);
        chk("bp_stall_gidx", gidx, 1);
        evt_if.evt_ready = 1'b1;
        @(negedge i_clk);
        chk("bp_next_valid", evt_if.evt_valid, 1);
        chk("bp_next_idx", evt_if.evt_idx, 1);
        chk("bp_next_level", evt_if.evt_level, 1);
        chk("bp_next_deb", deb, 4'b0011);
        @(negedge i_clk);
        chk("bp_drained", evt_if.evt_valid, 0);

        // Async reset while timing a second button.
        do_reset();
        i_btn[2] = 1'b1;
        c0 = cyc;
        wait_evt(c0, 40);
        repeat (3) @(negedge i_clk);
        i_btn[3] = 1'b1;
        repeat (6) @(negedge i_clk);
        chk("pre_rst_busy", busy, 1);
        #2 i_reset = 1'b1;
        #1;
        chk("rst_deb", deb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", evt_if.evt_valid, 0);
        chk("rst_gidx", gidx, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        c0 = cyc;
        wait_evt(c0, 40);
        chk("rst_restart_lat", cyc - c0, 12);
        chk("rst_restart_idx", evt_if.evt_idx, 2);
        repeat (30) @(negedge i_clk);

        // Randomized chatter with random backpressure.
        do_reset();
        repeat (4000) begin
            @(negedge i_clk);
            evt_if.evt_ready = ($urandom_range(2) != 0);
            for (int b = 0; b < NBTN; b++)
                if ($urandom_range(39) == 0) i_btn[b] = ~i_btn[b];
        end
        evt_if.evt_ready = 1'b1;
        repeat (60) @(negedge i_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
